// File: rtl/life_matrix_scan.sv
// Key-matrix scanner for the life grid: drives rows one at a time, debounces each
// row across two frames and emits changed rows as (index, data) writes.
module life_matrix_scan #(
  parameter int X      = 8,
  parameter int Y      = 8,
  parameter int LOG2X  = 3,
  parameter int LOG2Y  = 3,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [X-1:0]     row,
  input  logic [Y-1:0]     col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2X-1:0] out_row,
  output logic [Y-1:0]     out_data,
  input  logic             dump,
  output logic             frame_done,
  output logic [1:0]       dbg_state
);

  if (SETTLE < 3 || SETTLE > 15 || LOG2X < 1 || LOG2Y < 1) begin : g_bad_params
    $error("life_matrix_scan: SETTLE must be 3..15 and index widths non-zero");
  end

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  // out_valid/out_ready: a write transfers on a rising edge where both are 1;
  // while out_valid is 1 and out_ready is 0, out_row and out_data hold unchanged.
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [LOG2X-1:0]      idx_q, idx_d, idx_nxt;
  logic [X-1:0][Y-1:0]   stable_q, stable_d;
  logic [X-1:0][Y-1:0]   prev_q, prev_d;
  logic [Y-1:0]          col_m_q, col_s_q;
  logic                  pend_q, pend_d;
  logic                  dumping_q, dumping_d;
  logic [X-1:0]          row_q, row_d;
  logic                  out_valid_q, out_valid_d;
  logic [LOG2X-1:0]      out_row_q, out_row_d;
  logic [Y-1:0]          out_data_q, out_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  advance, wrap, chg;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    stable_d     = stable_q;
    prev_d       = prev_q;
    pend_d       = pend_q;
    dumping_d    = dumping_q;
    advance      = 1'b0;
    wrap         = (idx_q == LOG2X'(X - 1));
    idx_nxt      = wrap ? '0 : idx_q + LOG2X'(1);
    // A value counts only once it has read identically in two consecutive frames.
    chg          = (col_s_q == prev_q[idx_q]) && (col_s_q != stable_q[idx_q]);

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == 4'(SETTLE - 1)) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        prev_d[idx_q] = col_s_q;
        if (chg) stable_d[idx_q] = col_s_q;
        if (chg || dumping_q) state_d = ST_EMIT;
        else                  advance = 1'b1;
      end
      ST_EMIT: begin
        if (out_ready) advance = 1'b1;
      end
      default: state_d = ST_SETTLE;
    endcase

    if (advance) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
      idx_d   = idx_nxt;
    end

    // A dump request seen on the wrap itself is kept pending for the following frame.
    if (advance && wrap) begin
      dumping_d = pend_q;
      pend_d    = 1'b0;
    end
    if (dump) pend_d = 1'b1;

    row_d = '0;
    if (state_d != ST_EMIT) row_d[idx_d] = 1'b1;
    out_valid_d  = (state_d == ST_EMIT);
    out_row_d    = out_row_q;
    out_data_d   = out_data_q;
    if (state_q == ST_SAMPLE && state_d == ST_EMIT) begin
      out_row_d  = idx_q;
      out_data_d = stable_d[idx_q];
    end
    frame_done_d = advance && wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SETTLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      stable_q     <= '0;
      prev_q       <= '0;
      col_m_q      <= '0;
      col_s_q      <= '0;
      pend_q       <= 1'b0;
      dumping_q    <= 1'b0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stable_q     <= stable_d;
      prev_q       <= prev_d;
      col_m_q      <= col;
      col_s_q      <= col_m_q;
      pend_q       <= pend_d;
      dumping_q    <= dumping_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row        = row_q;
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_life_matrix_scan.sv
// Bench for life_matrix_scan: a per-frame key-matrix model predicts row writes into
// a queue that a separate monitor drains and compares on every accepted write.
module tb_life_matrix_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] row;
  logic [7:0] col;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_row;
  logic [7:0] out_data;
  logic       dump;
  logic       frame_done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  keys[8];
  logic [7:0]  keys_next[8];
  logic [7:0]  m_prev[8];
  logic [7:0]  m_stable[8];
  bit          m_dumping;
  bit          m_pend;
  int          ready_mode;

  always #5 clk = ~clk;

  life_matrix_scan #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .SETTLE(4)) dut (
    .clk(clk), .reset(rst_n), .row(row), .col(col), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_data(out_data), .dump(dump),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // The key matrix: the driven row connects its pressed keys to the column lines.
  always_comb begin
    col = '0;
    for (int r = 0; r < 8; r++) if (row[r]) col = keys[r];
  end

  always @(negedge clk) begin
    case (ready_mode)
      1:       out_ready <= ($urandom_range(0, 3) != 0);
      2:       out_ready <= 1'b0;
      default: out_ready <= 1'b1;
    endcase
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One frame of the matrix: each row read once, in order, against the debounce rules.
  task automatic start_frame();
    logic [7:0] s;
    bit         c;
    m_dumping = m_pend;
    m_pend    = 1'b0;
    for (int r = 0; r < 8; r++) keys[r] = keys_next[r];
    for (int r = 0; r < 8; r++) begin
      s = keys[r];
      c = (s == m_prev[r]) && (s != m_stable[r]);
      m_prev[r] = s;
      if (c) m_stable[r] = s;
      if (c || m_dumping) exp_q.push_back({3'(r), m_stable[r]});
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_prev[r]   = '0;
      m_stable[r] = '0;
    end
    m_pend    = 1'b0;
    m_dumping = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_frame_done();
    int n   = 0;
    bit got = 1'b0;
    while (n < 3000 && !got) begin
      @(negedge clk); #1;
      got = frame_done;
      n++;
    end
    check(got, "frame_done_timeout", int'(got), 1);
  endtask

  task automatic pulse_dump();
    @(negedge clk);
    dump   = 1'b1;
    m_pend = 1'b1;
    @(negedge clk);
    dump = 1'b0;
  endtask

  task automatic do_frame(input bit dump_mid);
    start_frame();
    if (dump_mid) begin
      repeat (7) @(negedge clk);
      pulse_dump();
    end
    wait_frame_done();
  endtask

  task automatic wait_valid(output bit got);
    int n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk); #1;
      got = out_valid;
      n++;
    end
    check(got, "valid_timeout", int'(got), 1);
  endtask

  // Monitor: pops the expected queue on each accepted write and checks EMIT behaviour.
  initial begin : monitor
    bit         hold   = 1'b0;
    bit         resume = 1'b0;
    logic [2:0] resume_row = '0;
    logic [2:0] hold_row   = '0;
    logic [7:0] hold_data  = '0;
    logic [7:0] oh;
    logic [10:0] e;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        hold   = 1'b0;
        resume = 1'b0;
      end else begin
        if (resume) begin
          oh = 8'b1 << resume_row;
          check(!out_valid && row == oh, "resume_row", int'(row), int'(oh));
          resume = 1'b0;
        end
        if (out_valid) begin
          check(row == 8'h00, "row_off_in_emit", int'(row), 0);
          if (hold)
            check({out_row, out_data} == {hold_row, hold_data}, "hold_stable",
                  int'({out_row, out_data}), int'({hold_row, hold_data}));
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check(1'b0, "unexpected_write", int'({out_row, out_data}), 0);
            end else begin
              e = exp_q.pop_front();
              check({out_row, out_data} == e, "write", int'({out_row, out_data}), int'(e));
              resume     = 1'b1;
              resume_row = e[10:8] + 3'd1;
            end
            hold = 1'b0;
          end else begin
            hold      = 1'b1;
            hold_row  = out_row;
            hold_data = out_data;
          end
        end else begin
          if (hold) check(1'b0, "valid_dropped", 0, 1);
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : main
    bit         got;
    logic [2:0] cap_row;
    logic [7:0] cap_data;
    logic [7:0] er;
    rst_n      = 1'b0;
    dump       = 1'b0;
    ready_mode = 0;
    for (int r = 0; r < 8; r++) begin
      keys[r]      = '0;
      keys_next[r] = '0;
    end
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check(row == 8'h00, "reset_row", int'(row), 0);
    check(out_valid == 1'b0, "reset_valid", int'(out_valid), 0);
    check(out_row == 3'd0, "reset_out_row", int'(out_row), 0);
    check(out_data == 8'h00, "reset_out_data", int'(out_data), 0);
    check(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: 5 cycles per row, 40-cycle frame.
    start_frame();
    wait_frame_done();
    start_frame();
    for (int t = 0; t < 40; t++) begin
      if (t > 0) begin
        @(negedge clk); #1;
        check(frame_done == 1'b0, "frame_done_spurious", int'(frame_done), 0);
      end
      er = 8'(1 << (t / 5));
      check(row == er, "row_scan", int'(row), int'(er));
    end
    @(negedge clk); #1;
    check(frame_done == 1'b1, "frame_period", int'(frame_done), 1);

    // Key r3,c5 held: written once, in the second frame.
    keys_next[3] = 8'h20;
    do_frame(1'b0);
    do_frame(1'b0);
    do_frame(1'b0);

    // One-frame glitch on r5: no write.
    keys_next[5] = 8'h01;
    do_frame(1'b0);
    keys_next[5] = 8'h00;
    do_frame(1'b0);
    do_frame(1'b0);

    // Release r3; the confirming write is held off for 10 cycles.
    keys_next[3] = 8'h00;
    do_frame(1'b0);
    start_frame();
    ready_mode = 2;
    wait_valid(got);
    cap_row  = out_row;
    cap_data = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check(out_valid && row == 8'h00 && out_row == cap_row && out_data == cap_data,
            "stall_hold", int'({out_valid, out_row, out_data}), int'({1'b1, cap_row, cap_data}));
    end
    ready_mode = 0;
    wait_frame_done();

    // Press r3 again, then a dump frame emitting all eight rows.
    keys_next[3] = 8'h20;
    do_frame(1'b0);
    do_frame(1'b1);
    ready_mode = 1;
    do_frame(1'b0);
    do_frame(1'b0);

    // Random key activity, dump requests and backpressure.
    for (int f = 0; f < 20; f++) begin
      for (int r = 0; r < 8; r++)
        if ($urandom_range(0, 3) == 0) keys_next[r] = 8'($urandom_range(0, 255));
      do_frame($urandom_range(0, 2) == 0);
    end
    ready_mode = 0;

    // Reset during a stalled write; held keys are re-emitted two frames later.
    keys_next[0] = 8'h81;
    keys_next[6] = 8'h3c;
    do_frame(1'b0);
    do_frame(1'b1);
    start_frame();
    ready_mode = 2;
    wait_valid(got);
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "async_reset_valid", int'(out_valid), 0);
    check(row == 8'h00, "async_reset_row", int'(row), 0);
    check(frame_done == 1'b0, "async_reset_frame_done", int'(frame_done), 0);
    model_reset();
    ready_mode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    wait_frame_done();
    do_frame(1'b0);
    do_frame(1'b0);

    repeat (5) @(negedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
